// File: rtl/shift_left_2.sv
// ============================================================================
// shift_left_2 : fixed logical left shift with registered result and overflow
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_left_2 #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic             in_valid,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic [SHIFT-1:0] shout_q,
  output logic             ovf_q,
  output logic             ovf_sticky
);

  logic [SHIFT-1:0] w_shout;
  logic             w_ovf;

  logic [WIDTH-1:0] y_d;
  logic             out_valid_d;
  logic [SHIFT-1:0] shout_d;
  logic             ovf_d;
  logic             ovf_sticky_d;
  logic             ovf_sticky_q;

  // Bits pushed past the MSB are kept so overflow is visible downstream.
  assign w_shout = a[WIDTH-1 -: SHIFT];
  assign w_ovf   = |w_shout;
  assign y       = {a[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};

  always_comb begin
    y_d          = y_q;
    shout_d      = shout_q;
    ovf_d        = ovf_q;
    out_valid_d  = in_valid;
    ovf_sticky_d = ovf_sticky_q;
    if (in_valid) begin
      y_d     = y;
      shout_d = w_shout;
      ovf_d   = w_ovf;
    end
    // Clear wins over a coincident overflowing input.
    if (clr_sticky) begin
      ovf_sticky_d = 1'b0;
    end else if (in_valid && w_ovf) begin
      ovf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q          <= '0;
      shout_q      <= '0;
      ovf_q        <= 1'b0;
      out_valid    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      y_q          <= y_d;
      shout_q      <= shout_d;
      ovf_q        <= ovf_d;
      out_valid    <= out_valid_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_left_2.sv
// ============================================================================
// tb_shift_left_2 : directed and randomized checks against a behavioural model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_left_2;

  localparam int WIDTH = 16;
  localparam int SHIFT = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic             in_valid = 1'b0;
  logic             clr_sticky = 1'b0;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             out_valid;
  logic [SHIFT-1:0] shout_q;
  logic             ovf_q;
  logic             ovf_sticky;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, updated arithmetically at each rising edge.
  int m_y_q = 0;
  int m_shout = 0;
  int m_ovf = 0;
  int m_valid = 0;
  int m_sticky = 0;

  shift_left_2 #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .in_valid   (in_valid),
    .clr_sticky (clr_sticky),
    .y          (y),
    .y_q        (y_q),
    .out_valid  (out_valid),
    .shout_q    (shout_q),
    .ovf_q      (ovf_q),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  function automatic int model_y(input int av);
    return (av * (2 ** SHIFT)) % (2 ** WIDTH);
  endfunction

  task automatic drive(input logic [WIDTH-1:0] av, input logic v, input logic c, input logic r);
    @(negedge clk);
    a = av;
    in_valid = v;
    clr_sticky = c;
    reset = r;
    #1;
  endtask

  task automatic tick();
    int av;
    @(posedge clk);
    av = int'(a);
    if (reset) begin
      m_y_q = 0; m_shout = 0; m_ovf = 0; m_valid = 0; m_sticky = 0;
    end else begin
      m_valid = in_valid ? 1 : 0;
      if (in_valid) begin
        m_y_q   = model_y(av);
        m_shout = av / (2 ** (WIDTH - SHIFT));
        m_ovf   = (m_shout != 0) ? 1 : 0;
      end
      if (clr_sticky) m_sticky = 0;
      else if (in_valid && av >= 2 ** (WIDTH - SHIFT)) m_sticky = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(16'h1234, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    n_checks++;
    if ({y_q, shout_q, ovf_q, out_valid, ovf_sticky} !== '0) begin
      n_errors++;
      $display("FAIL reset_regs: got y_q=%h shout=%b ovf=%b vld=%b stk=%b, expected all 0",
               y_q, shout_q, ovf_q, out_valid, ovf_sticky);
    end
    n_checks++;
    if (y !== 16'h48D0) begin
      n_errors++;
      $display("FAIL reset_comb_y: got %h expected 48d0", y);
    end
  endtask

  task automatic test_vectors();
    drive(16'hFFFF, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (y !== 16'hFFFC) begin n_errors++; $display("FAIL ffff_y: got %h expected fffc", y); end
    tick();
    n_checks++;
    if (y_q !== 16'hFFFC || shout_q !== 2'b11 || ovf_q !== 1'b1 || ovf_sticky !== 1'b1 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL ffff_reg: got y_q=%h shout=%b ovf=%b stk=%b vld=%b expected fffc 11 1 1 1",
               y_q, shout_q, ovf_q, ovf_sticky, out_valid);
    end
    drive(16'hABCD, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (y !== 16'hAF34) begin n_errors++; $display("FAIL abcd_y: got %h expected af34", y); end
    tick();
    n_checks++;
    if (y_q !== 16'hAF34 || shout_q !== 2'b10 || ovf_q !== 1'b1) begin
      n_errors++;
      $display("FAIL abcd_reg: got y_q=%h shout=%b ovf=%b expected af34 10 1", y_q, shout_q, ovf_q);
    end
    drive(16'h0001, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (y_q !== 16'h0004 || shout_q !== 2'b00 || ovf_q !== 1'b0) begin
      n_errors++;
      $display("FAIL 0001_reg: got y_q=%h shout=%b ovf=%b expected 0004 00 0", y_q, shout_q, ovf_q);
    end
    drive(16'h3FFF, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (y !== 16'hFFFC) begin n_errors++; $display("FAIL 3fff_y: got %h expected fffc", y); end
    tick();
    n_checks++;
    if (y_q !== 16'hFFFC || ovf_q !== 1'b0 || ovf_sticky !== 1'b1) begin
      n_errors++;
      $display("FAIL 3fff_reg: got y_q=%h ovf=%b stk=%b expected fffc 0 1", y_q, ovf_q, ovf_sticky);
    end
  endtask

  task automatic test_reset_with_valid();
    drive(16'hFFFF, 1'b1, 1'b0, 1'b1);
    tick();
    n_checks++;
    if ({y_q, shout_q, ovf_q, out_valid, ovf_sticky} !== '0 || y !== 16'hFFFC) begin
      n_errors++;
      $display("FAIL reset_valid: got y_q=%h shout=%b ovf=%b vld=%b stk=%b y=%h expected 0s and y=fffc",
               y_q, shout_q, ovf_q, out_valid, ovf_sticky, y);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_seq [3];
    exp_seq[0] = 16'h0004; exp_seq[1] = 16'h0008; exp_seq[2] = 16'h000C;
    for (int i = 0; i < 3; i++) begin
      drive(WIDTH'(i + 1), 1'b1, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (y_q !== exp_seq[i] || out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_%0d: got y_q=%h vld=%b expected %h 1", i, y_q, out_valid, exp_seq[i]);
      end
    end
    drive(16'h5555, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || y_q !== 16'h000C) begin
      n_errors++;
      $display("FAIL bubble: got vld=%b y_q=%h expected 0 000c", out_valid, y_q);
    end
    drive(16'h0004, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || y_q !== 16'h0010) begin
      n_errors++;
      $display("FAIL after_bubble: got vld=%b y_q=%h expected 1 0010", out_valid, y_q);
    end
  endtask

  task automatic test_sticky_clear();
    drive(16'h8000, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ovf_sticky !== 1'b1 || shout_q !== 2'b10) begin
      n_errors++;
      $display("FAIL sticky_set: got stk=%b shout=%b expected 1 10", ovf_sticky, shout_q);
    end
    drive(16'h8000, 1'b1, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (ovf_sticky !== 1'b0 || ovf_q !== 1'b1) begin
      n_errors++;
      $display("FAIL sticky_clr_prio: got stk=%b ovf=%b expected 0 1", ovf_sticky, ovf_q);
    end
    drive(16'hC000, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ovf_sticky !== 1'b0 || ovf_q !== 1'b1 || shout_q !== 2'b10) begin
      n_errors++;
      $display("FAIL sticky_no_valid: got stk=%b ovf=%b shout=%b expected 0 1 10", ovf_sticky, ovf_q, shout_q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(WIDTH'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 32) == 0);
      n_checks++;
      if (int'(y) !== model_y(int'(a))) begin
        n_errors++;
        $display("FAIL rand_y_%0d: a=%h got %h expected %h", i, a, y, model_y(int'(a)));
      end
      tick();
      n_checks++;
      if (int'(y_q) !== m_y_q || int'(shout_q) !== m_shout || int'(ovf_q) !== m_ovf ||
          int'(out_valid) !== m_valid || int'(ovf_sticky) !== m_sticky) begin
        n_errors++;
        $display("FAIL rand_reg_%0d: got y_q=%h shout=%0d ovf=%b vld=%b stk=%b expected %h %0d %0d %0d %0d",
                 i, y_q, shout_q, ovf_q, out_valid, ovf_sticky, m_y_q, m_shout, m_ovf, m_valid, m_sticky);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_reset_with_valid();
    test_back_to_back();
    test_sticky_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
